// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the CPU request side, the DMA BR/BG handshake and the data-memory
//   control outputs of the CPU/DMA memory-port arbiter.
//   slave  : arbiter view (CPU/DMA requests in, grant/stall/memory mux out)
//   master : view of the agent that drives CPU/DMA requests and observes
//            the arbiter outputs
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int WORD_SIZE = 16
);
   // CPU side
   logic                 cpu_readM;
   logic                 cpu_writeM;
   logic [WORD_SIZE-1:0] cpu_address;
   logic                 cpu_mem_busy;
   logic                 cpu_stall;
   // DMA side
   logic                 BR;
   logic                 BG;
   logic                 dma_write;
   logic [WORD_SIZE-1:0] dma_addr;
   logic [1:0]           dma_offset;
   // Memory side
   logic                 mem_readM;
   logic                 mem_writeM;
   logic [WORD_SIZE-1:0] mem_address;
   // Status
   logic                 grant_overrun;

   modport slave (
      input  cpu_readM, cpu_writeM, cpu_address, cpu_mem_busy,
      input  BR, dma_write, dma_addr, dma_offset,
      output BG, cpu_stall, mem_readM, mem_writeM, mem_address, grant_overrun
   );

   modport master (
      output cpu_readM, cpu_writeM, cpu_address, cpu_mem_busy,
      output BR, dma_write, dma_addr, dma_offset,
      input  BG, cpu_stall, mem_readM, mem_writeM, mem_address, grant_overrun
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the data-memory port between the CPU and the DMA engine using the
//   BR/BG handshake. An in-flight CPU access is allowed to finish before the
//   grant, the CPU memory stage is stalled while DMA owns the bus, and after
//   each DMA release the CPU keeps the bus for a minimum holdoff window.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_bus_arbiter_if.slave
//           in  cpu_readM/cpu_writeM/cpu_address/cpu_mem_busy, BR,
//               dma_write/dma_addr/dma_offset
//           out BG (registered), cpu_stall, mem_readM/mem_writeM/mem_address,
//               grant_overrun (sticky)
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int WORD_SIZE        = 16,
   parameter int CPU_MIN_CYCLES   = 4,
   parameter int MAX_GRANT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   mem_bus_arbiter_if.slave   bus
);

   localparam int HW = (CPU_MIN_CYCLES > 0) ? $clog2(CPU_MIN_CYCLES + 1) : 1;
   // One spare count above MAX so saturation never lands back on MAX.
   localparam int CW = $clog2(MAX_GRANT_CYCLES + 2);

   typedef enum logic [1:0] {
      S_CPU   = 2'd0,
      S_DRAIN = 2'd1,
      S_GRANT = 2'd2,
      S_TURN  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] holdoff_q, holdoff_d;
   logic [CW-1:0] grant_cnt_q, grant_cnt_d;
   logic          overrun_q, overrun_d;
   logic          bg_q;

   logic                 cpu_req;
   logic                 stall;
   logic                 rd, wr;
   logic [WORD_SIZE-1:0] addr;
   logic [WORD_SIZE-1:0] dma_line_addr;

   assign cpu_req       = bus.cpu_readM | bus.cpu_writeM;
   // Line addresses step by 4 words; the sum wraps modulo 2^WORD_SIZE.
   assign dma_line_addr = bus.dma_addr + WORD_SIZE'({bus.dma_offset, 2'b00});

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_CPU;
         holdoff_q   <= '0;
         grant_cnt_q <= '0;
         overrun_q   <= 1'b0;
         bg_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         holdoff_q   <= holdoff_d;
         grant_cnt_q <= grant_cnt_d;
         overrun_q   <= overrun_d;
         // BG comes straight from a flop so the DMA sees a glitch-free grant.
         bg_q        <= (state_d == S_GRANT);
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      holdoff_d   = holdoff_q;
      grant_cnt_d = grant_cnt_q;
      overrun_d   = overrun_q;
      unique case (state_q)
         S_CPU: begin
            if (holdoff_q != '0) holdoff_d = holdoff_q - 1'b1;
            // A request raised during holdoff simply waits here until it expires.
            if (bus.BR && holdoff_q == '0)
               state_d = (cpu_req || bus.cpu_mem_busy) ? S_DRAIN : S_GRANT;
         end
         S_DRAIN: begin
            if (!bus.BR)                state_d = S_CPU;
            else if (!bus.cpu_mem_busy) state_d = S_GRANT;
         end
         S_GRANT: begin
            if (grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 1'b1;
            if (grant_cnt_q == CW'(MAX_GRANT_CYCLES)) overrun_d = 1'b1;
            if (!bus.BR) state_d = S_TURN;
         end
         S_TURN: begin
            state_d     = S_CPU;
            holdoff_d   = HW'(CPU_MIN_CYCLES);
            grant_cnt_d = '0;
         end
         default: state_d = S_CPU;
      endcase
   end

   // -------------------------------------------------------- output mux
   always_comb begin
      stall = 1'b0;
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      unique case (state_q)
         S_CPU, S_DRAIN: begin
            // While draining, the in-flight access runs on; only a new one is held.
            if (state_q == S_DRAIN) stall = !bus.cpu_mem_busy && cpu_req;
            rd   = bus.cpu_readM  & !stall;
            wr   = bus.cpu_writeM & !stall;
            addr = bus.cpu_address;
         end
         S_GRANT: begin
            stall = 1'b1;
            wr    = bus.dma_write;
            addr  = dma_line_addr;
         end
         S_TURN: begin
            stall = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.BG            = bg_q;
   assign bus.cpu_stall     = stall;
   assign bus.mem_readM     = rd;
   assign bus.mem_writeM    = wr;
   assign bus.mem_address   = addr;
   assign bus.grant_overrun = overrun_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed scenarios followed by randomized traffic. Each cycle the driver
//   advances a reference model of the arbitration rules and queues the outputs
//   expected for the inputs it just applied; a monitor on the falling edge
//   pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int MINC = 4;
   localparam int MAXG = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.WORD_SIZE(16)) bus ();

   mem_bus_arbiter #(
      .WORD_SIZE(16), .CPU_MIN_CYCLES(MINC), .MAX_GRANT_CYCLES(MAXG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        bg, stall, rd, wr, ovr;
      logic [15:0] addr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   // Bus ownership tracked as flags and counters: who holds the bus, whether
   // we are waiting on the CPU, the turnaround cycle, CPU cooldown left, and
   // how long the current grant has lasted.
   bit m_dma, m_wait, m_turn, m_ovr;
   int m_cool, m_glen;

   function automatic void model_step();
      if (reset) begin
         m_dma = 0; m_wait = 0; m_turn = 0; m_ovr = 0; m_cool = 0; m_glen = 0;
      end else if (m_turn) begin
         m_turn = 0; m_cool = MINC; m_glen = 0;
      end else if (m_dma) begin
         if (m_glen == MAXG) m_ovr = 1;
         m_glen++;
         if (!bus.BR) begin m_dma = 0; m_turn = 1; end
      end else if (m_wait) begin
         if (!bus.BR) m_wait = 0;
         else if (!bus.cpu_mem_busy) begin m_wait = 0; m_dma = 1; end
      end else begin
         if (bus.BR && m_cool == 0) begin
            if (bus.cpu_readM || bus.cpu_writeM || bus.cpu_mem_busy) m_wait = 1;
            else m_dma = 1;
         end
         if (m_cool > 0) m_cool--;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int   a;
      e.bg = m_dma; e.ovr = m_ovr;
      e.stall = 0; e.rd = 0; e.wr = 0; e.addr = 16'h0;
      if (m_turn) begin
         e.stall = 1;
      end else if (m_dma) begin
         e.stall = 1;
         e.wr    = bus.dma_write;
         a       = (int'(bus.dma_addr) + 4 * int'(bus.dma_offset)) % 65536;
         e.addr  = a[15:0];
      end else begin
         if (m_wait) e.stall = !bus.cpu_mem_busy && (bus.cpu_readM || bus.cpu_writeM);
         e.rd   = bus.cpu_readM  && !e.stall;
         e.wr   = bus.cpu_writeM && !e.stall;
         e.addr = bus.cpu_address;
      end
      return e;
   endfunction

   // One clock: advance model on the edge, apply the next inputs, queue the
   // expectation. Returns 3 time units after the edge.
   task automatic cycle(input logic rd, input logic wr, input logic [15:0] ca,
                        input logic busy, input logic br, input logic dw,
                        input logic [15:0] da, input logic [1:0] off);
      @(posedge clk);
      model_step();
      #2;
      bus.cpu_readM = rd; bus.cpu_writeM = wr; bus.cpu_address = ca;
      bus.cpu_mem_busy = busy; bus.BR = br; bus.dma_write = dw;
      bus.dma_addr = da; bus.dma_offset = off;
      q.push_back(model_out());
      #1;
   endtask

   // ------------------------------------------------------------- monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("BG",            32'(bus.BG),            32'(e.bg));
            chk("cpu_stall",     32'(bus.cpu_stall),     32'(e.stall));
            chk("mem_readM",     32'(bus.mem_readM),     32'(e.rd));
            chk("mem_writeM",    32'(bus.mem_writeM),    32'(e.wr));
            chk("mem_address",   32'(bus.mem_address),   32'(e.addr));
            chk("grant_overrun", 32'(bus.grant_overrun), 32'(e.ovr));
         end
      end
   end

   // -------------------------------------------------------------- driver
   initial begin
      logic br;
      reset = 1'b1;
      bus.cpu_readM = 0; bus.cpu_writeM = 0; bus.cpu_address = 16'h1234;
      bus.cpu_mem_busy = 0; bus.BR = 0; bus.dma_write = 0;
      bus.dma_addr = 16'h0; bus.dma_offset = 2'd0;

      // Reset state: CPU owns the bus, CPU read passes through.
      cycle(1, 0, 16'h1234, 0, 0, 0, 16'h0, 0);
      cycle(1, 0, 16'h1234, 0, 0, 0, 16'h0, 0);
      chk("rst_BG",    32'(bus.BG), 0);
      chk("rst_ovr",   32'(bus.grant_overrun), 0);
      chk("rst_stall", 32'(bus.cpu_stall), 0);
      chk("rst_rd",    32'(bus.mem_readM), 1);
      reset = 1'b0;

      // Idle CPU, BR rises: grant one edge later, DMA line address.
      cycle(0, 0, 16'h0, 0, 1, 1, 16'h01F0, 3);
      chk("lat_BG_lo", 32'(bus.BG), 0);
      cycle(0, 0, 16'h0, 0, 1, 1, 16'h01F0, 3);
      chk("lat_BG_hi", 32'(bus.BG), 1);
      chk("dma_addr",  32'(bus.mem_address), 32'h01FC);
      chk("dma_wr",    32'(bus.mem_writeM), 1);
      for (int i = 0; i < 11; i++) cycle(1, 1, 16'h0, 0, 1, 0, 16'h0100, 2'(i));
      // Release, then re-request during turnaround and holdoff.
      cycle(0, 0, 16'h0, 0, 0, 1, 16'h0100, 0);
      cycle(0, 1, 16'h0, 0, 1, 1, 16'h0100, 0);
      chk("turn_BG",   32'(bus.BG), 0);
      chk("turn_wr",   32'(bus.mem_writeM), 0);
      chk("turn_addr", 32'(bus.mem_address), 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 16'h0, 0, 1, 0, 16'hFFFC, 2);
         chk("holdoff_BG", 32'(bus.BG), 0);
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 0, 1, 0, 16'hFFFC, 2);
      chk("wrap_BG",   32'(bus.BG), 1);
      chk("wrap_addr", 32'(bus.mem_address), 32'h0004);
      cycle(0, 0, 16'h0, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 0, 0, 0, 16'h0, 0);

      // One-cycle BR pulse while the CPU is busy: drain, then back to CPU.
      cycle(1, 0, 16'h0042, 1, 1, 1, 16'h0, 0);
      cycle(1, 0, 16'h0042, 1, 0, 1, 16'h0, 0);
      chk("drain_rd",    32'(bus.mem_readM), 1);
      chk("drain_stall", 32'(bus.cpu_stall), 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 16'h0, 0, 0, 1, 16'h0, 0);
         chk("pulse_BG", 32'(bus.BG), 0);
      end

      // Busy for 3 cycles while BR is held: grant only after busy clears.
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 16'h0077, 1, 1, 0, 16'h0200, 1);
         chk("busy_BG", 32'(bus.BG), 0);
      end
      cycle(0, 0, 16'h0, 0, 1, 0, 16'h0200, 1);
      chk("busy_BG2", 32'(bus.BG), 0);
      cycle(0, 0, 16'h0, 0, 1, 0, 16'h0200, 1);
      chk("busy_BG3", 32'(bus.BG), 1);

      // Long grant: overrun flagged, grant kept, then async reset mid-grant.
      for (int i = 0; i < 70; i++) cycle(0, 0, 16'h0, 0, 1, 0, 16'h0300, 0);
      chk("ovr_flag", 32'(bus.grant_overrun), 1);
      chk("ovr_BG",   32'(bus.BG), 1);
      #4 reset = 1'b1;
      #1;
      chk("arst_BG",    32'(bus.BG), 0);
      chk("arst_stall", 32'(bus.cpu_stall), 0);
      chk("arst_ovr",   32'(bus.grant_overrun), 0);
      cycle(0, 0, 16'h0, 0, 0, 0, 16'h0, 0);
      reset = 1'b0;
      cycle(0, 0, 16'h0, 0, 0, 0, 16'h0, 0);

      // Randomized traffic, BR held for random stretches.
      br = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0) br = ~br;
         cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
               16'($urandom), 1'($urandom_range(0, 3) == 0), br,
               1'($urandom), 16'($urandom), 2'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
